// File: rtl/spi_reg_bank.sv
// SPI-mode-0 register bank: serial write frames commit to a flat register file.
// Define SPI_READBACK_EN to build the CIPO readback shifter for read frames.
module spi_reg_bank #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic                         frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    // [0] first sync stage, [1] synchronized value, [2] history
    logic [2:0]           ncs_pipe_r;
    logic [2:0]           sclk_pipe_r;
    logic [2:0]           copi_pipe_r;
    logic                 live_r;
    logic                 armed_r;
    logic [1:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [FRAME_LEN-1:0] shift_r;

    logic                 ncs_fall_s;
    logic                 ncs_rise_s;
    logic                 sclk_rise_s;
    logic                 copi_s;
    logic                 rw_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [DATA_W-1:0]    data_s;
    logic                 addr_ok_s;

    // Input synchronizers; armed_r blocks the false nCS fall seen when the
    // reset value (1) drains out while the pin is still held low mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_pipe_r  <= 3'b111;
            sclk_pipe_r <= 3'b000;
            copi_pipe_r <= 3'b000;
            live_r      <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            ncs_pipe_r  <= {ncs_pipe_r[1:0], nCS};
            sclk_pipe_r <= {sclk_pipe_r[1:0], SCLK};
            copi_pipe_r <= {copi_pipe_r[1:0], COPI};
            live_r      <= 1'b1;
            if (live_r && ncs_pipe_r[0]) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign ncs_fall_s  = armed_r & ncs_pipe_r[2] & ~ncs_pipe_r[1];
    assign ncs_rise_s  = ~ncs_pipe_r[2] & ncs_pipe_r[1];
    assign sclk_rise_s = ~sclk_pipe_r[2] & sclk_pipe_r[1];
    assign copi_s      = copi_pipe_r[2];

    assign rw_s      = shift_r[FRAME_LEN-1];
    assign addr_s    = shift_r[DATA_W +: ADDR_W];
    assign data_s    = shift_r[DATA_W-1:0];
    assign addr_ok_s = ({1'b0, addr_s} < NUM_REGS_X);

    // Frame FSM, input shifter and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            shift_r   <= '0;
            regs_flat <= '0;
            wr_stb    <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_stb    <= '0;
            frame_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ncs_fall_s) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= '0;
                        shift_r <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise_s) begin
                        if (cnt_r == CNT_FULL) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            state_r   <= ST_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise_s && (cnt_r < CNT_FULL)) begin
                        shift_r <= {shift_r[FRAME_LEN-2:0], copi_s};
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                    if (rw_s && addr_ok_s) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_s == ADDR_W'(i)) begin
                                regs_flat[i*DATA_W +: DATA_W] <= data_s;
                                wr_stb[i]                     <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);

    logic [DATA_W-1:0] out_sh_r;
    logic              rd_loaded_r;
    logic              oe_r;
    logic              sclk_fall_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_data_s;

    assign sclk_fall_s = sclk_pipe_r[2] & ~sclk_pipe_r[1];
    assign rd_addr_s   = shift_r[ADDR_W-1:0];

    // Read mux; out-of-range addresses fall through to zero
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (rd_addr_s == ADDR_W'(i)) ? regs_flat[i*DATA_W +: DATA_W] : rd_data_s;
        end
    end

    // Output shifter: load once the address is in, then shift on SCLK falls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sh_r    <= '0;
            rd_loaded_r <= 1'b0;
            oe_r        <= 1'b0;
        end else begin
            oe_r <= ~ncs_pipe_r[0];
            if ((state_r != ST_SHIFT) || ncs_rise_s) begin
                out_sh_r    <= '0;
                rd_loaded_r <= 1'b0;
            end else if (sclk_fall_s) begin
                if (rd_loaded_r) begin
                    out_sh_r <= {out_sh_r[DATA_W-2:0], 1'b0};
                end else if ((cnt_r == CNT_ADDR) && !shift_r[ADDR_W]) begin
                    out_sh_r    <= rd_data_s;
                    rd_loaded_r <= 1'b1;
                end
            end
        end
    end

    assign CIPO    = out_sh_r[DATA_W-1];
    assign cipo_oe = oe_r;
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default instance plus a wide-frame instance
// (ADDR_W=4, DATA_W=16, NUM_REGS=16) sharing the same SPI pins.
module tb_spi_reg_bank;

    localparam int HALF = 80;

    logic           clk = 1'b0;
    logic           rst;
    logic           ncs_pin;
    logic           sclk_pin;
    logic           copi_pin;
    logic           cipo;
    logic           oe;
    logic [39:0]    rf;
    logic [4:0]     stb;
    logic           ferr;
    logic           w_cipo;
    logic           w_oe;
    logic [255:0]   w_rf;
    logic [15:0]    w_stb;
    logic           w_ferr;

    int checks = 0;
    int errors = 0;
    int stb_cnt [5];
    int stb_base [5];
    int err_cnt = 0;
    int err_base = 0;
    int w15_cnt = 0;
    int w15_base = 0;
    logic [31:0] rx;
    logic        oe_seen;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .nCS(ncs_pin), .SCLK(sclk_pin), .COPI(copi_pin),
        .CIPO(cipo), .cipo_oe(oe), .regs_flat(rf), .wr_stb(stb), .frame_err(ferr)
    );

    spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) dut_w (
        .clk(clk), .rst(rst), .nCS(ncs_pin), .SCLK(sclk_pin), .COPI(copi_pin),
        .CIPO(w_cipo), .cipo_oe(w_oe), .regs_flat(w_rf), .wr_stb(w_stb), .frame_err(w_ferr)
    );

    always #5 clk = ~clk;

    // Pulse counters for strobes and frame errors
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (stb[i]) stb_cnt[i]++;
        end
        if (ferr) err_cnt++;
        if (w_stb[15]) w15_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) stb_base[i] = stb_cnt[i];
        err_base = err_cnt;
        w15_base = w15_cnt;
    endtask

    function automatic int stb_delta(input int i);
        return stb_cnt[i] - stb_base[i];
    endfunction

    function automatic int stb_total();
        int t = 0;
        for (int i = 0; i < 5; i++) t += stb_cnt[i] - stb_base[i];
        return t;
    endfunction

    // One SPI frame; optional one-clk rst pulse after rst_at SCLK edges
    task automatic frame(input logic [31:0] bits, input int nbits, input int nedges,
                         input int rst_at, output logic [31:0] rxd, output logic oe_first);
        rxd = 32'h0;
        oe_first = 1'b0;
        @(negedge clk);
        copi_pin = bits[nbits-1];
        ncs_pin  = 1'b0;
        #HALF;
        for (int i = 0; i < nedges; i++) begin
            copi_pin = (i < nbits) ? bits[nbits-1-i] : 1'b0;
            #HALF;
            sclk_pin = 1'b1;
            rxd = {rxd[30:0], cipo};
            if (i == 0) oe_first = oe;
            #HALF;
            sclk_pin = 1'b0;
            if (i + 1 == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        #HALF;
        ncs_pin = 1'b1;
        #200;
    endtask

    initial begin
        rst = 1'b1;
        ncs_pin = 1'b1;
        sclk_pin = 1'b0;
        copi_pin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_regs", {24'h0, rf}, 64'h0);
        check("rst_stb", {59'h0, stb}, 64'h0);
        check("rst_ferr", {63'h0, ferr}, 64'h0);
        check("rst_cipo", {62'h0, cipo, oe}, 64'h0);
        check("rst_w", {61'h0, w_cipo, w_oe, w_ferr}, 64'h0);
        check("rst_w_regs", {63'h0, |w_rf}, 64'h0);

        // Write reg0 = A5
        snap();
        frame(32'h80A5, 16, 16, 0, rx, oe_seen);
        check("wr0_regs", {24'h0, rf}, 64'h00000000A5);
        check("wr0_stb0", stb_delta(0), 64'd1);
        check("wr0_stbtot", stb_total(), 64'd1);
        check("wr0_err", err_cnt - err_base, 64'd0);

        // Write reg4 = 3C, then drop write to 0x7F
        frame(32'h843C, 16, 16, 0, rx, oe_seen);
        check("wr4_regs", {24'h0, rf}, 64'h3C000000A5);
        check("wr4_stb4", stb_delta(4), 64'd1);
        snap();
        frame(32'hFFFF, 16, 16, 0, rx, oe_seen);
        check("oor_regs", {24'h0, rf}, 64'h3C000000A5);
        check("oor_stb", stb_total(), 64'd0);
        check("oor_err", err_cnt - err_base, 64'd0);

        // Short frame: 12 edges
        snap();
        frame(32'h8177, 16, 12, 0, rx, oe_seen);
        check("short_err", err_cnt - err_base, 64'd1);
        check("short_regs", {24'h0, rf}, 64'h3C000000A5);
        check("short_stb", stb_total(), 64'd0);

        // reg2 = 5A, then read it back
        frame(32'h825A, 16, 16, 0, rx, oe_seen);
        check("wr2_regs", {24'h0, rf}, 64'h3C005A00A5);
        snap();
        frame(32'h0200, 16, 16, 0, rx, oe_seen);
`ifdef SPI_READBACK_EN
        check("rd_data", {48'h0, rx[15:0]}, 64'h005A);
        check("rd_oe", {63'h0, oe_seen}, 64'h1);
`else
        check("rd_data", {48'h0, rx[15:0]}, 64'h0000);
        check("rd_oe", {63'h0, oe_seen}, 64'h0);
`endif
        check("rd_regs", {24'h0, rf}, 64'h3C005A00A5);
        check("rd_stb", stb_total(), 64'd0);
        check("rd_err", err_cnt - err_base, 64'd0);
        check("rd_cipo_idle", {63'h0, cipo}, 64'h0);

        // Reset after 9 edges of a write to reg1, then a clean write
        snap();
        frame(32'h8199, 16, 16, 9, rx, oe_seen);
        check("mrst_regs", {24'h0, rf}, 64'h0);
        check("mrst_stb", stb_total(), 64'd0);
        snap();
        frame(32'h8111, 16, 16, 0, rx, oe_seen);
        check("wr1_regs", {24'h0, rf}, 64'h0000001100);
        check("wr1_stb1", stb_delta(1), 64'd1);

        // 21-bit frame for wide instance; default instance sees addr 0x7D
        snap();
        frame(32'h1FBEEF, 21, 21, 0, rx, oe_seen);
        check("wide_reg15", {48'h0, w_rf[255:240]}, 64'hBEEF);
        check("wide_rest", {63'h0, |w_rf[239:0]}, 64'h0);
        check("wide_stb15", w15_cnt - w15_base, 64'd1);
        check("wide_dflt_regs", {24'h0, rf}, 64'h0000001100);
        check("wide_dflt_err", err_cnt - err_base, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
